csr_reg_file: RTL and testbench

Machine-mode CSR register file and trap unit for the 3-stage RV32I pipeline; it is the responder to the decoder's `csr_rd`, `csr_wr` and `is_mret` controls. It sits alongside the register file in the execute/writeback stage. It serves CSRRW reads and writes, and arbitrates timer and external interrupts into traps. It also produces a one-cycle PC redirect (`epc_taken`/`epc`) for both trap entry and `mret` return.

---
 rtl/csr_pkg.sv | 34 +++
 rtl/csr_reg_file.sv | 183 ++++++++++++++++++
 tb/tb_csr_reg_file.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_pkg.sv
// +----------------------------------------------------------------------------+
// | csr_pkg                                                                    |
// | CSR addresses, bit positions, cause codes and FSM states for csr_reg_file. |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package csr_pkg;

    localparam logic [11:0] C_ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] C_ADDR_MIE     = 12'h304;
    localparam logic [11:0] C_ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] C_ADDR_MEPC    = 12'h341;
    localparam logic [11:0] C_ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] C_ADDR_MIP     = 12'h344;

    localparam int unsigned C_MSTATUS_MIE  = 3;
    localparam int unsigned C_MSTATUS_MPIE = 7;
    localparam int unsigned C_MIE_MTIE     = 7;
    localparam int unsigned C_MIE_MEIE     = 11;
    localparam int unsigned C_MIP_MTIP     = 7;
    localparam int unsigned C_MIP_MEIP     = 11;

    localparam logic [3:0] C_CAUSE_MTI = 4'd7;
    localparam logic [3:0] C_CAUSE_MEI = 4'd11;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_REDIRECT = 1'b1
    } csr_state_e;

endpackage

`default_nettype wire

// File: rtl/csr_reg_file.sv
// +----------------------------------------------------------------------------+
// | csr_reg_file                                                               |
// | Machine-mode CSRs and interrupt trap/mret redirect unit.                   |
// | Option: define CSR_VECTORED_EN for vectored mtvec mode.                    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module csr_reg_file
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic [31:0] pc,
    input  logic        csr_rd,
    input  logic        csr_wr,
    input  logic        is_mret,
    input  logic        timer_intr,
    input  logic        ext_intr,
    output logic [31:0] csr_rdata,
    output logic [31:0] epc,
    output logic        epc_taken
);

    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic        r_mie_mtie;
    logic        r_mie_meie;
    logic [29:0] r_mtvec_base;
    logic [29:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_epc;
    logic        r_epc_taken;
    csr_state_e  r_state;
    csr_state_e  w_state_nxt;

    logic        w_mtvec_mode;
    logic        w_pending;
    logic [3:0]  w_code;
    logic [31:0] w_vector;
    logic        w_trap;
    logic        w_mret;
    logic        w_wr_en;
    logic [31:0] w_epc_nxt;
    logic        w_epc_taken_nxt;
    logic        w_unused;

`ifdef CSR_VECTORED_EN
    logic r_mtvec_mode;
    assign w_mtvec_mode = r_mtvec_mode;
`else
    assign w_mtvec_mode = 1'b0;
`endif

    assign w_unused  = ^pc[1:0];
    assign w_pending = r_mstatus_mie &
                       ((r_mie_mtie & timer_intr) | (r_mie_meie & ext_intr));
    // External wins when both sources are enabled and pending.
    assign w_code    = (r_mie_meie & ext_intr) ? C_CAUSE_MEI : C_CAUSE_MTI;
    assign w_vector  = w_mtvec_mode ? ({r_mtvec_base, 2'b00} + {26'b0, w_code, 2'b00})
                                    : {r_mtvec_base, 2'b00};

    assign epc       = r_epc;
    assign epc_taken = r_epc_taken;

    always_comb begin
        w_state_nxt     = r_state;
        w_trap          = 1'b0;
        w_mret          = 1'b0;
        w_wr_en         = 1'b0;
        w_epc_nxt       = r_epc;
        w_epc_taken_nxt = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_pending) begin
                    // Any CSR write or mret in this slot is dropped and re-executes from mepc.
                    w_trap          = 1'b1;
                    w_epc_nxt       = w_vector;
                    w_epc_taken_nxt = 1'b1;
                    w_state_nxt     = ST_REDIRECT;
                end else begin
                    w_wr_en = csr_wr;
                    if (is_mret) begin
                        w_mret          = 1'b1;
                        w_epc_nxt       = {r_mepc, 2'b00};
                        w_epc_taken_nxt = 1'b1;
                        w_state_nxt     = ST_REDIRECT;
                    end
                end
            end
            ST_REDIRECT: w_state_nxt = ST_RUN;
            default:     w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_epc       <= 32'h0;
            r_epc_taken <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_epc       <= w_epc_nxt;
            r_epc_taken <= w_epc_taken_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie_mtie     <= 1'b0;
            r_mie_meie     <= 1'b0;
            r_mtvec_base   <= 30'h0;
            r_mepc         <= 30'h0;
            r_mcause       <= 32'h0;
`ifdef CSR_VECTORED_EN
            r_mtvec_mode   <= 1'b0;
`endif
        end else begin
            if (w_wr_en) begin
                case (csr_addr)
                    C_ADDR_MSTATUS: begin
                        r_mstatus_mie  <= csr_wdata[C_MSTATUS_MIE];
                        r_mstatus_mpie <= csr_wdata[C_MSTATUS_MPIE];
                    end
                    C_ADDR_MIE: begin
                        r_mie_mtie <= csr_wdata[C_MIE_MTIE];
                        r_mie_meie <= csr_wdata[C_MIE_MEIE];
                    end
                    C_ADDR_MTVEC: begin
                        r_mtvec_base <= csr_wdata[31:2];
`ifdef CSR_VECTORED_EN
                        r_mtvec_mode <= csr_wdata[0];
`endif
                    end
                    C_ADDR_MEPC:   r_mepc   <= csr_wdata[31:2];
                    C_ADDR_MCAUSE: r_mcause <= csr_wdata;
                    default: ;
                endcase
            end
            if (w_trap) begin
                r_mepc         <= pc[31:2];
                r_mcause       <= {1'b1, 27'b0, w_code};
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
            end
            if (w_mret) begin
                r_mstatus_mie  <= r_mstatus_mpie;
                r_mstatus_mpie <= 1'b1;
            end
        end
    end

    always_comb begin
        csr_rdata = 32'h0;
        if (csr_rd) begin
            case (csr_addr)
                C_ADDR_MSTATUS: begin
                    csr_rdata[C_MSTATUS_MIE]  = r_mstatus_mie;
                    csr_rdata[C_MSTATUS_MPIE] = r_mstatus_mpie;
                end
                C_ADDR_MIE: begin
                    csr_rdata[C_MIE_MTIE] = r_mie_mtie;
                    csr_rdata[C_MIE_MEIE] = r_mie_meie;
                end
                C_ADDR_MTVEC:  csr_rdata = {r_mtvec_base, 1'b0, w_mtvec_mode};
                C_ADDR_MEPC:   csr_rdata = {r_mepc, 2'b00};
                C_ADDR_MCAUSE: csr_rdata = r_mcause;
                C_ADDR_MIP: begin
                    csr_rdata[C_MIP_MTIP] = timer_intr;
                    csr_rdata[C_MIP_MEIP] = ext_intr;
                end
                default: csr_rdata = 32'h0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_csr_reg_file.sv
// +----------------------------------------------------------------------------+
// | tb_csr_reg_file                                                            |
// | Self-checking bench for csr_reg_file with a behavioural CSR model.         |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_csr_reg_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] pc;
    logic        csr_rd;
    logic        csr_wr;
    logic        is_mret;
    logic        timer_intr;
    logic        ext_intr;
    logic [31:0] csr_rdata;
    logic [31:0] epc;
    logic        epc_taken;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef CSR_VECTORED_EN
    localparam logic [31:0] C_MTVEC_MASK = 32'hFFFF_FFFD;
    localparam logic [31:0] C_EXP_VEC    = 32'h0000_012C;
    localparam logic [31:0] C_EXP_MTVEC  = 32'h0000_1001;
`else
    localparam logic [31:0] C_MTVEC_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] C_EXP_VEC    = 32'h0000_0100;
    localparam logic [31:0] C_EXP_MTVEC  = 32'h0000_1000;
`endif

    logic [11:0] addrs [8] = '{12'h300, 12'h304, 12'h305, 12'h341,
                               12'h342, 12'h344, 12'h301, 12'h7C0};

    // Architectural view of the CSRs, kept as whole 32-bit words
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause, m_epc;
    bit          m_taken, m_redir;

    csr_reg_file u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .csr_addr   (csr_addr),
        .csr_wdata  (csr_wdata),
        .pc         (pc),
        .csr_rd     (csr_rd),
        .csr_wr     (csr_wr),
        .is_mret    (is_mret),
        .timer_intr (timer_intr),
        .ext_intr   (ext_intr),
        .csr_rdata  (csr_rdata),
        .epc        (epc),
        .epc_taken  (epc_taken)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_read(input logic [11:0] a, input logic rd);
        if (!rd) return 32'h0;
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return {20'b0, ext_intr, 3'b0, timer_intr, 7'b0};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_mstatus = 0; m_mie = 0; m_mtvec = 0; m_mepc = 0; m_mcause = 0;
        m_epc = 0; m_taken = 0; m_redir = 0;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [11:0] a,
                         input logic [31:0] wd, input logic [31:0] p,
                         input logic mret, input logic ti, input logic ei);
        csr_rd = rd; csr_wr = wr; csr_addr = a; csr_wdata = wd; pc = p;
        is_mret = mret; timer_intr = ti; ext_intr = ei;
    endtask

    // Advance the model by one cycle from the current inputs, then clock the DUT.
    task automatic tick();
        logic [31:0] mip, base;
        int code;
        mip = {20'b0, ext_intr, 3'b0, timer_intr, 7'b0};
        if (m_redir) begin
            m_redir = 0;
            m_taken = 0;
        end else if (m_mstatus[3] && ((m_mie & mip) != 0)) begin
            code      = (m_mie[11] && ext_intr) ? 11 : 7;
            m_mepc    = pc & 32'hFFFF_FFFC;
            m_mcause  = 32'h8000_0000 | 32'(code);
            m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
            base      = m_mtvec & 32'hFFFF_FFFC;
            m_epc     = m_mtvec[0] ? base + 32'(4 * code) : base;
            m_taken   = 1;
            m_redir   = 1;
        end else begin
            if (csr_wr) begin
                case (csr_addr)
                    12'h300: m_mstatus = csr_wdata & 32'h88;
                    12'h304: m_mie     = csr_wdata & 32'h880;
                    12'h305: m_mtvec   = csr_wdata & C_MTVEC_MASK;
                    12'h341: m_mepc    = csr_wdata & 32'hFFFF_FFFC;
                    12'h342: m_mcause  = csr_wdata;
                    default: ;
                endcase
            end
            if (is_mret) begin
                m_mstatus = (m_mstatus[7] ? 32'h8 : 32'h0) | 32'h80;
                m_epc     = m_mepc;
                m_taken   = 1;
                m_redir   = 1;
            end else begin
                m_taken = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr_csr(input logic [11:0] a, input logic [31:0] d);
        drive(0, 1, a, d, 32'h0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        drive(0, 0, 12'h0, 32'h0, 32'h0, 0, 0, 0);
        #2;
        n_tests++;
        if (epc_taken !== 1'b0 || epc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: epc_taken=%b epc=%h, want 0/0", epc_taken, epc);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, addrs[i], 32'h0, 32'h0, 0, 0, 0);
            #1;
            n_tests++;
            if (csr_rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_read %h: got %h want 0", addrs[i], csr_rdata);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 12'h0, 32'h0, 32'h0, 0, 0, 0);
        tick();
    endtask

    task automatic test_mtvec_write();
        wr_csr(12'h305, 32'h0000_1001);
        drive(1, 0, 12'h305, 32'h0, 32'h0, 0, 0, 0);
        #1;
        n_tests++;
        if (csr_rdata !== C_EXP_MTVEC) begin
            n_fail++;
            $display("FAIL mtvec_read: got %h want %h", csr_rdata, C_EXP_MTVEC);
        end
        tick();
    endtask

    task automatic test_timer_trap();
        wr_csr(12'h305, 32'h0000_0100);
        wr_csr(12'h304, 32'h0000_0080);
        wr_csr(12'h300, 32'h0000_0008);
        drive(0, 0, 12'h0, 32'h0, 32'h40, 0, 1, 0);
        tick();
        n_tests++;
        if (epc_taken !== 1'b1 || epc !== 32'h100) begin
            n_fail++;
            $display("FAIL timer_redirect: epc_taken=%b epc=%h want 1/00000100", epc_taken, epc);
        end
        drive(1, 0, 12'h341, 32'h0, 32'h0, 0, 0, 0);
        #1;
        n_tests++;
        if (csr_rdata !== 32'h40) begin
            n_fail++;
            $display("FAIL timer_mepc: got %h want 00000040", csr_rdata);
        end
        csr_addr = 12'h342;
        #1;
        n_tests++;
        if (csr_rdata !== 32'h8000_0007) begin
            n_fail++;
            $display("FAIL timer_mcause: got %h want 80000007", csr_rdata);
        end
        csr_addr = 12'h300;
        #1;
        n_tests++;
        if (csr_rdata !== 32'h80) begin
            n_fail++;
            $display("FAIL timer_mstatus: got %h want 00000080", csr_rdata);
        end
        tick();
        n_tests++;
        if (epc_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL timer_pulse_width: epc_taken=%b want 0", epc_taken);
        end
    endtask

    task automatic test_both_intr();
        wr_csr(12'h305, 32'h0000_0101);
        wr_csr(12'h304, 32'h0000_0880);
        wr_csr(12'h300, 32'h0000_0008);
        drive(0, 0, 12'h0, 32'h0, 32'h80, 0, 1, 1);
        tick();
        n_tests++;
        if (epc_taken !== 1'b1 || epc !== C_EXP_VEC) begin
            n_fail++;
            $display("FAIL both_redirect: epc_taken=%b epc=%h want 1/%h", epc_taken, epc, C_EXP_VEC);
        end
        drive(1, 0, 12'h342, 32'h0, 32'h0, 0, 0, 0);
        #1;
        n_tests++;
        if (csr_rdata !== 32'h8000_000B) begin
            n_fail++;
            $display("FAIL both_mcause: got %h want 8000000b", csr_rdata);
        end
        tick();
    endtask

    task automatic test_mret();
        wr_csr(12'h341, 32'h0000_0040);
        wr_csr(12'h300, 32'h0000_0080);
        drive(0, 0, 12'h0, 32'h0, 32'h0, 1, 0, 0);
        tick();
        n_tests++;
        if (epc_taken !== 1'b1 || epc !== 32'h40) begin
            n_fail++;
            $display("FAIL mret_redirect: epc_taken=%b epc=%h want 1/00000040", epc_taken, epc);
        end
        drive(1, 0, 12'h300, 32'h0, 32'h0, 0, 0, 0);
        #1;
        n_tests++;
        if (csr_rdata !== 32'h88) begin
            n_fail++;
            $display("FAIL mret_mstatus: got %h want 00000088", csr_rdata);
        end
        tick();
        n_tests++;
        if (epc_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL mret_pulse_width: epc_taken=%b want 0", epc_taken);
        end
    endtask

    task automatic test_trap_drops_write();
        wr_csr(12'h304, 32'h0000_0080);
        wr_csr(12'h300, 32'h0000_0008);
        drive(0, 1, 12'h341, 32'hDEAD_BEE0, 32'h200, 0, 1, 0);
        tick();
        n_tests++;
        if (epc_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_redirect: epc_taken=%b want 1", epc_taken);
        end
        drive(1, 0, 12'h341, 32'h0, 32'h0, 0, 0, 0);
        #1;
        n_tests++;
        if (csr_rdata !== 32'h200) begin
            n_fail++;
            $display("FAIL drop_mepc: got %h want 00000200", csr_rdata);
        end
        tick();
    endtask

    task automatic test_random();
        logic rd, wr, mret, ti, ei;
        int r;
        for (int i = 0; i < 600; i++) begin
            r    = $urandom_range(0, 9);
            rd   = 1'($urandom_range(0, 1));
            wr   = (r < 4);
            mret = (r == 4 || r == 5);
            ti   = ($urandom_range(0, 5) == 0);
            ei   = ($urandom_range(0, 5) == 0);
            drive(rd, wr, addrs[$urandom_range(0, 7)], $urandom, $urandom, mret, ti, ei);
            #1;
            n_tests++;
            if (csr_rdata !== model_read(csr_addr, csr_rd)) begin
                n_fail++;
                $display("FAIL rand_read[%0d] addr=%h: got %h want %h",
                         i, csr_addr, csr_rdata, model_read(csr_addr, csr_rd));
            end
            tick();
            n_tests++;
            if (epc_taken !== m_taken || epc !== m_epc) begin
                n_fail++;
                $display("FAIL rand_redirect[%0d]: epc_taken=%b epc=%h want %b/%h",
                         i, epc_taken, epc, m_taken, m_epc);
            end
        end
    endtask

    task automatic test_reset_mid_redirect();
        drive(0, 0, 12'h0, 32'h0, 32'h0, 0, 0, 0);
        tick();
        wr_csr(12'h304, 32'h0000_0800);
        wr_csr(12'h300, 32'h0000_0008);
        drive(0, 0, 12'h0, 32'h0, 32'h300, 0, 0, 1);
        tick();
        n_tests++;
        if (epc_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: epc_taken=%b want 1", epc_taken);
        end
        rst_n = 1'b0;
        model_reset();
        ext_intr = 1'b0;
        #1;
        n_tests++;
        if (epc_taken !== 1'b0 || epc !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: epc_taken=%b epc=%h want 0/0", epc_taken, epc);
        end
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, addrs[i], 32'h0, 32'h0, 0, 0, 0);
            #1;
            n_tests++;
            if (csr_rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL rstmid_read %h: got %h want 0", addrs[i], csr_rdata);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 12'h0, 32'h0, 32'h0, 0, 0, 0);
        tick();
        n_tests++;
        if (epc_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_after: epc_taken=%b want 0", epc_taken);
        end
    endtask

    initial begin
        test_reset();
        test_mtvec_write();
        test_timer_trap();
        test_both_intr();
        test_mret();
        test_trap_drops_write();
        test_random();
        test_reset_mid_redirect();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
